// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: size encodings,
// FSM states, latency bounds and the byte-lane enable decoder.
package dm_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;

  typedef enum logic [1:0] {StIdle, StWait, StDone} dm_state_e;

  // Bit 3 is the lane at bits 31:24 (byte offset 0, big-endian).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = addr_lo[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: be = 4'b1000 >> addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational store-lane merge: replicates right-justified store data into the
// selected big-endian lanes and flags misaligned half/word accesses.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] merged_o,
  output logic [3:0]  be_o,
  output logic        misalign_o
);

  logic [31:0] repl;

  always_comb begin
    be_o = lane_be(size_i, addr_lo_i);
    unique case (size_i)
      SZ_HALF: repl = {2{wdata_i[15:0]}};
      SZ_BYTE: repl = {4{wdata_i[7:0]}};
      default: repl = wdata_i;
    endcase
    // Reserved size behaves as a word.
    if (size_i == SZ_HALF) begin
      misalign_o = addr_lo_i[0];
    end else if (size_i == SZ_BYTE) begin
      misalign_o = 1'b0;
    end else begin
      misalign_o = (addr_lo_i != 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = be_o[i] ? repl[8*i +: 8] : old_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: answers MEM-stage loads/stores from a word array, holding
// FREEZE for LATENCY cycles per access. `define DM_PARITY_EN adds per-lane parity.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemRead_2DM,
  input  logic              MemWrite_2DM,
  input  logic [ADDR_W-1:0] data_address_2DM,
  input  logic [31:0]       data_write_2DM,
  input  logic [1:0]        MemSize_2DM,
  output logic [31:0]       data_read_fDM,
  output logic              FREEZE,
  output logic              dm_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(LAT_MAX + 1);
  localparam logic [CntW-1:0] CntInit = CntW'((LATENCY > LAT_MIN) ? LATENCY - 2 : 0);

  dm_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              both_q, both_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic              req, enter_done, ok, commit, oob, misalign, par_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, old_word, merged;
  logic [1:0]        acc_size;
  logic              acc_we, acc_both;
  logic [IdxW-1:0]   idx;
  logic [3:0]        be;

  assign req    = MemRead_2DM | MemWrite_2DM;
  assign FREEZE = ((state_q == StIdle) && req) || (state_q == StWait);

  // With LATENCY==1 the commit edge is the accept edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = data_address_2DM;
      acc_wdata = data_write_2DM;
      acc_size  = MemSize_2DM;
      acc_we    = MemWrite_2DM;
      acc_both  = MemRead_2DM & MemWrite_2DM;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_we    = we_q;
      acc_both  = both_q;
    end
  end

  assign idx      = acc_addr[IdxW+1:2];
  assign oob      = (acc_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  assign old_word = mem_q[idx];

  dm_lane_merge u_merge (
    .addr_lo_i  (acc_addr[1:0]),
    .size_i     (acc_size),
    .wdata_i    (acc_wdata),
    .old_i      (old_word),
    .merged_o   (merged),
    .be_o       (be),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    we_d       = we_q;
    both_d     = both_q;
    enter_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = data_address_2DM;
          wdata_d = data_write_2DM;
          size_d  = MemSize_2DM;
          we_d    = MemWrite_2DM;
          both_d  = MemRead_2DM & MemWrite_2DM;
          cnt_d   = CntInit;
          if (LATENCY <= LAT_MIN) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StDone;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ok      = !misalign && !oob;
    commit  = enter_done && acc_we && ok;
    rdata_d = rdata_q;
    if (enter_done && !acc_we) begin
      rdata_d = ok ? old_word : 32'd0;
    end
    err_d = enter_done && (!ok || acc_both || (acc_size == 2'b11) || par_err);
  end

`ifdef DM_PARITY_EN
  logic [3:0] par_q [DEPTH];
  logic [3:0] par_rd;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      par_rd[i] = ^old_word[8*i +: 8];
    end
  end

  assign par_err = enter_done && !acc_we && ok && (par_rd != par_q[idx]);

  always_ff @(posedge CLK) begin
    if (RESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) par_q[idx][i] <= ^merged[8*i +: 8];
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Array contents survive reset; a reset on the commit edge drops the store.
  always_ff @(posedge CLK) begin
    if (RESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= merged[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      both_q  <= both_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign data_read_fDM = rdata_q;
  assign dm_err        = err_q;

endmodule
